// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus a shift-add 32x32 multiplier (low word).
// Latency: non-MUL ops done 1 cycle after accept; MUL done 33 cycles after accept.
// Backpressure: start is sampled only in IDLE; requests while busy (MULT or DONE) are dropped.
module mc_alu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    // Counter must reach MUL_CYCLES itself, hence the +1 in the width.
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               mul_last;
    logic               is_mul;

    assign is_mul   = (alucontrol == OP_MUL);
    assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
    // Accumulator value after the current iteration; also the final product on the last one.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Single-cycle operations; unknown codes (and MUL, handled elsewhere) give 0.
    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle and ignores start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = is_mul ? MULT : DONE;
                end
            end
            MULT: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: result/zero only change on completion; multiplier runs the full count even for zero operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                        end
                    end
                end
                MULT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (mul_last) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data path width, fixed at 32 for this revision.
REQ-002 SHALL have parameter MUL_CYCLES, default 32: number of multiplier iterations, equal to WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port alucontrol, input, 4 bits: operation code, the consumer side of the ALU control decoder encoding.
REQ-007 SHALL have port a, input, 32 bits: operand A (rs).
REQ-008 SHALL have port b, input, 32 bits: operand B (rt or immediate).
REQ-009 SHALL have port shamt, input, 5 bits: shift amount.
REQ-010 SHALL have port result, output, 32 bits: registered result, held until the next accepted operation completes.
REQ-011 SHALL have port zero, output, 1 bit: registered, high when result is 0.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking that result and zero are valid and updated.

Function
REQ-014 SHALL implement the states IDLE, MULT and DONE.
REQ-015 SHALL decode the following codes:
- 0010 ADD: a+b.
- 0110 SUB: a-b.
- 0000 AND: a&b.
- 0001 OR: a|b.
- 1100 NOR: ~(a|b).
- 0111 SLT: 1 if signed a<b, else 0.
- 0011 SLL: b<<shamt.
- 1011 SRL: b>>shamt, logical.
- 1111 MUL: low 32 bits of a*b.
REQ-016 SHALL wrap ADD, SUB and MUL modulo 2^32 and SHALL NOT flag overflow.
REQ-017 SHALL, for any other alucontrol code, produce result 0 and zero 1 with single-cycle latency.
REQ-018 SHALL, on IDLE with start=1 and a non-MUL code, register result and zero at that edge and go to DONE.
REQ-019 SHALL, on IDLE with start=1 and code 1111, capture a into the multiplicand register, capture b into the multiplier register, clear the accumulator and counter, and go to MULT.
REQ-020 SHALL, on each MULT cycle:
- add the multiplicand to the accumulator if multiplier bit 0 is 1;
- shift the multiplicand left by 1;
- shift the multiplier right by 1;
- increment the counter.
REQ-021 SHALL, after the MUL_CYCLES-th MULT iteration, load the final accumulator into result, update zero and go to DONE.
REQ-022 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-023 SHALL give a non-MUL operation latency of 1 cycle: done is high in the cycle after the start cycle.
REQ-024 SHALL give MUL a latency of 33 cycles from the start cycle to done.
REQ-025 SHALL ignore start while busy=1, including in DONE; a back-to-back operation is accepted at the earliest in the cycle after done.
REQ-026 SHALL make operands and alucontrol don't-care after acceptance; MUL uses only its captured copies.
REQ-027 SHALL leave result and zero unchanged in IDLE and MULT until completion.
REQ-028 SHALL NOT terminate a multiplication early, even when operands are zero.

Reset
REQ-029 SHALL, when rst_n=0, immediately and asynchronously force:
- state IDLE;
- result 0, zero 1, busy 0, done 0;
- the accumulator, multiplicand, multiplier and counter to 0.
REQ-030 SHALL abort an in-progress MULT on reset without producing a done pulse.
REQ-031 SHALL, on release of rst_n, accept start on the first following rising edge.

Verification
REQ-032 SHALL verify ADD and SUB: ADD a=7, b=5 -> done 1 cycle later with result 12, zero 0; then SUB a=5, b=5 -> result 0, zero 1.
REQ-033 SHALL verify SLT, SLL and SRL:
- SLT a=0xFFFFFFFF, b=1 -> result 1;
- SLL b=1, shamt=31 -> 0x80000000;
- SRL b=0x80000000, shamt=31 -> 1.
REQ-034 SHALL verify MUL a=0x00010001, b=0x00010001 -> busy for 33 cycles, then done with result 0x00020001 (wrapped low word).
REQ-035 SHALL verify busy handling: start pulsed with ADD codes during MUL busy -> ignored; MUL result unaffected; exactly one done pulse.
REQ-036 SHALL verify reset abort: rst_n asserted at MULT cycle 10 -> busy 0, result 0, zero 1, no done; a following ADD 1+1 -> result 2.
REQ-037 SHALL verify undefined codes: alucontrol=0100 with start -> done next cycle, result 0, zero 1.
